// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux stimulus/capture sequencer.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int PATTERN_W   = 11;
  localparam int PATTERN_MAX = 2047;

  // Bit positions inside rec_data = {idx, pattern, out}
  localparam int REC_OUT_LSB = 0;
  localparam int REC_PAT_LSB = 1;
  localparam int REC_IDX_LSB = 12;

endpackage

// File: rtl/mux_seq_rec_if.sv
// Record handshake toward the dataset logger: {idx, pattern, out} over valid/ready.
interface mux_seq_rec_if #(
  parameter int IDX_W = 17
);
  logic               rec_valid;
  logic               rec_ready;
  logic [IDX_W+11:0]  rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/mux_pattern_counter.sv
// 11-bit stimulus pattern register; clear has priority over increment.
module mux_pattern_counter
  import mux_seq_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [PATTERN_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == PATTERN_W'(PATTERN_MAX)) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_sample_sequencer.sv
// Sweeps the 8:1 mux input space, waits for settling, captures one record per pattern.
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   SETTLE | pattern driven, counting down settle cycles
//   EMIT   | record held on rec_* until rec_ready
//   DONE   | final record accepted, done held until next start
module mux_sample_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SAMPLE_COUNT  = 100000,
  parameter int IDX_W         = 17,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [7:0]           d,
  output logic [2:0]           s,
  input  logic                 mux_out,
  mux_seq_rec_if.master        rec,
  output logic                 busy,
  output logic                 done
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam int REC_W = REC_IDX_LSB + IDX_W;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [SET_W-1:0]       settle_cnt;
  logic [PATTERN_W-1:0]   pattern;
  logic [REC_W-1:0]       rec_next;
  logic                   start_ok;
  logic                   accept;
  logic                   last;

  assign start_ok = ((state == IDLE) || (state == DONE)) && start;
  assign accept   = (state == EMIT) && rec.rec_ready;
  assign last     = (idx == IDX_W'(SAMPLE_COUNT - 1));

  mux_pattern_counter u_pattern (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start_ok),
    .inc     (accept && !last),
    .count   (pattern)
  );

  // Pattern bit 10 is D0, so the data bus is the top byte reversed; selects likewise.
  always_comb begin
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[i] = pattern[PATTERN_W-1-i];
    end
    s = {pattern[0], pattern[1], pattern[2]};
  end

  always_comb begin
    rec_next                             = '0;
    rec_next[REC_OUT_LSB]                = mux_out;
    rec_next[REC_PAT_LSB +: PATTERN_W]   = pattern;
    rec_next[REC_IDX_LSB +: IDX_W]       = idx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      settle_cnt    <= '0;
      rec.rec_valid <= 1'b0;
      rec.rec_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            rec.rec_data  <= rec_next;
            rec.rec_valid <= 1'b1;
            state         <= EMIT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        EMIT: begin
          if (rec.rec_ready) begin
            rec.rec_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              idx        <= idx + 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sample_sequencer.sv
// Directed bench: short run with backpressure/restart on one instance, wrap and mid-run reset on another.
module tb_mux_sample_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, start_a, start_b;
  logic [7:0] d_a, d_b;
  logic [2:0] s_a, s_b;
  logic       mux_out_a, mux_out_b;
  logic       busy_a, done_a, busy_b, done_b;

  mux_seq_rec_if #(.IDX_W(3))  rec_a ();
  mux_seq_rec_if #(.IDX_W(12)) rec_b ();

  // Golden 8:1 mux: select value is {S2,S1,S0}
  assign mux_out_a = d_a[s_a];
  assign mux_out_b = d_b[s_b];

  mux_sample_sequencer #(.SAMPLE_COUNT(4), .IDX_W(3), .SETTLE_CYCLES(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .d(d_a), .s(s_a),
    .mux_out(mux_out_a), .rec(rec_a), .busy(busy_a), .done(done_a)
  );

  mux_sample_sequencer #(.SAMPLE_COUNT(2050), .IDX_W(12), .SETTLE_CYCLES(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .d(d_b), .s(s_b),
    .mux_out(mux_out_b), .rec(rec_b), .busy(busy_b), .done(done_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected mux output for a pattern: D_i = p[10-i], select = {p[0],p[1],p[2]}
  function automatic logic exp_out(input logic [10:0] p);
    int sel;
    sel = {p[0], p[1], p[2]};
    return p[10 - sel];
  endfunction

  function automatic logic [10:0] exp_ds(input logic [10:0] p);
    logic [7:0] dv;
    for (int i = 0; i < 8; i++) dv[i] = p[10 - i];
    return {dv, p[0], p[1], p[2]};
  endfunction

  task automatic wait_a(input int max, output int n);
    n = 0;
    while (rec_a.rec_valid !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
    if (rec_a.rec_valid !== 1'b1) chk("timeout_a", rec_a.rec_valid, 1);
  endtask

  task automatic wait_b(input int max, output int n);
    n = 0;
    while (rec_b.rec_valid !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
    if (rec_b.rec_valid !== 1'b1) chk("timeout_b", rec_b.rec_valid, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    logic [10:0] p;
    logic [14:0] snap_data;
    logic [10:0] snap_ds;

    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rec_a.rec_ready = 1'b0; rec_b.rec_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_valid_a", rec_a.rec_valid, 0);
    chk("rst_data_a", rec_a.rec_data, 0);
    chk("rst_ds_a", {d_a, s_a}, 0);
    chk("rst_busy_done_a", {busy_a, done_a}, 0);
    chk("rst_all_b", {rec_b.rec_valid, rec_b.rec_data, d_b, s_b, busy_b, done_b}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_after_release", {rec_a.rec_valid, busy_a, done_a, d_a, s_a,
                               rec_b.rec_valid, busy_b, done_b, d_b, s_b}, 0);

    // Basic run, ready tied high
    rec_a.rec_ready = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk("start_busy_a", {busy_a, rec_a.rec_valid}, 2'b10);
    for (int r = 0; r < 4; r++) begin
      p = 11'(r);
      wait_a(8, n);
      chk(r == 0 ? "first_lat_a" : "period_a", n, 1);
      chk("basic_rec_a", rec_a.rec_data, {3'(r), p, exp_out(p)});
      chk("basic_ds_a", {d_a, s_a}, exp_ds(p));
      @(negedge clock);
    end
    chk("done_a", {done_a, busy_a, rec_a.rec_valid}, 3'b100);

    // Restart from DONE, backpressure on idx 2 with a start pulse during EMIT
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk("restart_done_clr_a", {done_a, busy_a}, 2'b01);
    chk("restart_pat_a", {d_a, s_a}, 0);
    for (int r = 0; r < 4; r++) begin
      p = 11'(r);
      wait_a(8, n);
      chk("bp_rec_a", rec_a.rec_data, {3'(r), p, exp_out(p)});
      if (r == 2) begin
        snap_data = rec_a.rec_data;
        snap_ds   = {d_a, s_a};
        rec_a.rec_ready = 1'b0;
        start_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          start_a = 1'b0;
          chk("bp_hold_a", {rec_a.rec_valid, busy_a, rec_a.rec_data, d_a, s_a},
                           {2'b11, snap_data, snap_ds});
        end
        rec_a.rec_ready = 1'b1;
      end
      @(negedge clock);
    end
    chk("bp_done_a", {done_a, busy_a}, 2'b10);

    // Long run through the pattern wrap, settle of two cycles
    rec_b.rec_ready = 1'b1;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    bad = 0;
    for (int r = 0; r < 2050; r++) begin
      p = 11'(r);
      wait_b(10, n);
      if (r == 0) chk("first_lat_b", n, 2);
      else if (n != 2) bad++;
      if (r < 2 || r > 2045)
        chk("wrap_rec_b", rec_b.rec_data, {12'(r), p, exp_out(p)});
      @(negedge clock);
    end
    chk("period_b_bad", bad, 0);
    chk("done_b", {done_b, busy_b}, 2'b10);

    // Restart then reset while idx 7 is pending
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    chk("restart_done_clr_b", done_b, 0);
    for (int r = 0; r < 8; r++) begin
      wait_b(10, n);
      if (r < 7) @(negedge clock);
    end
    chk("pre_rst_idx7_b", rec_b.rec_data, {12'd7, 11'd7, exp_out(11'd7)});
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid_b", rec_b.rec_valid, 0);
    chk("async_rst_all", {rec_b.rec_data, d_b, s_b, busy_b, done_b, done_a, d_a, s_a}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    wait_b(10, n);
    chk("post_rst_lat_b", n, 2);
    chk("post_rst_rec_b", rec_b.rec_data, {12'd0, 11'd0, exp_out(11'd0)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_sample_sequencer.md
# mux_sample_sequencer

Synthesizable stimulus-and-capture stage that sits directly upstream of the 8:1 `mux` block and directly feeds the dataset logger. It sweeps the mux's 11-bit input space (D0..D7, S0..S2) in counting order and lets each pattern settle. It then samples the mux output and emits one record per pattern over a valid/ready handshake, producing the same `index, D0..D7, S0..S2, out` sequence that the dataset flow consumes.

## Interface
Parameters:
- `SAMPLE_COUNT`, default 100000: number of records per run (≥1).
- `IDX_W`, default 17: sample-index width; must satisfy 2^IDX_W ≥ SAMPLE_COUNT.
- `SETTLE_CYCLES`, default 1: cycles each pattern is held before sampling (≥1).

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `d` out 8: mux data inputs; `d[0]`=D0 … `d[7]`=D7.
- `s` out 3: mux selects; `s[0]`=S0, `s[1]`=S1, `s[2]`=S2.
- `mux_out` in 1: mux output, combinationally dependent on `d`/`s`.
- `rec_valid` out 1: record available.
- `rec_ready` in 1: logger accepts record.
- `rec_data` out IDX_W+12: `{idx, pattern[10:0], out}`; pattern bit 10=D0 … bit 3=D7, bit 2=S0, bit 1=S1, bit 0=S2.
- `busy` out 1: run in progress.
- `done` out 1: last record accepted; held until next `start`.

## Operation
- Internal 11-bit `pattern`. `d[i]` is driven from `pattern[10-i]`. `s[0]`/`s[1]`/`s[2]` are driven from `pattern[2]`/`pattern[1]`/`pattern[0]`.
- Internal `idx` (IDX_W bits) and settle counter.
- FSM states: IDLE, SETTLE, EMIT, DONE.
  - IDLE/DONE, `start`=1: `pattern`←0, `idx`←0, `done`←0, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles. On the last one, capture `{idx, pattern, mux_out}` into `rec_data`, set `rec_valid`←1, go to EMIT.
  - EMIT: hold `rec_valid` and `rec_data` stable until `rec_ready`=1.
    - On accept with `idx`=SAMPLE_COUNT-1: `rec_valid`←0, `done`←1, go to DONE.
    - Otherwise: `rec_valid`←0, `idx`←`idx`+1, `pattern`←`pattern`+1 (wraps 2047→0), go to SETTLE.
- `start` is ignored in SETTLE and EMIT.
- `busy` = state ∈ {SETTLE, EMIT}.
- `pattern` and `d`/`s` change only on an accepted handshake or on `start`. They never change while `rec_valid`=1.
- Reset values: state IDLE; `pattern`, `idx`, `d`, `s`, `rec_data` all 0; `rec_valid`, `busy`, `done` all 0.
- Reset asserted mid-run aborts immediately. An in-flight record is dropped with no partial handshake.

## Timing
- Start edge k enters SETTLE; `d`/`s` are valid after edge k.
- `rec_valid` rises at edge k+SETTLE_CYCLES.
- Handshake at edge j: `rec_valid` is low from j. The next pattern is driven from j, and `rec_valid` rises again at j+SETTLE_CYCLES.
- With `rec_ready` tied high, throughput is one record per SETTLE_CYCLES+1 cycles.
- `mux_out` is sampled at the capture edge only. The `mux` path must settle within SETTLE_CYCLES cycles.
- `done` rises on the edge that accepts the final record.

## Structure
- Package `mux_seq_pkg` holds:
  - the state enum (IDLE, SETTLE, EMIT, DONE);
  - `PATTERN_W`=11 and `PATTERN_MAX`=2047;
  - `rec_data` field offsets: `REC_OUT_LSB`=0, `REC_PAT_LSB`=1, `REC_IDX_LSB`=12.
- One sub-module, `mux_pattern_counter`: 11-bit wrapping counter with `clr` and `inc` inputs, asynchronous active-low reset.
- FSM, settle counter and record register stay in the top level.

## Test plan
- **Reset:** assert `reset_n`=0 at any state → all outputs 0, state IDLE. Release → outputs remain 0 until `start`.
- **Basic run:** SAMPLE_COUNT=4, SETTLE_CYCLES=1, `rec_ready`=1, golden mux model on `mux_out`.
  - Required records: idx 0..3 with patterns 0..3, each `out` matching the model.
  - `rec_valid` period is 2 cycles.
  - `done`=1 after the 4th accept.
- **Backpressure:** `rec_ready` low for 5 cycles during record idx 2 → `rec_data` and `d`/`s` stay stable. Exactly one record is transferred with idx 2. No skip and no duplicate.
- **Wrap:** SAMPLE_COUNT=2050 → idx 2047 carries pattern 2047, idx 2048 carries pattern 0, idx 2049 carries pattern 1. `done` follows idx 2049.
- **Start while busy / restart:**
  - `start` pulsed during EMIT → no effect on the sequence.
  - `start` in DONE → `done`←0, new run from idx 0, pattern 0.
- **Reset mid-run:** assert `reset_n` while `rec_valid`=1 at idx 7 → `rec_valid` drops asynchronously, outputs are 0. Next `start` begins at idx 0.
